fft_input_loader: RTL

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

---
 rtl/fft_input_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fft_input_loader.sv
// Ping-pong style frame loader: streams ADC samples into four FFT input banks,
// launches the core once the frame is full and counts samples lost while busy.

module fft_bank_port #(
  parameter int ADDR_W = 9
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [ADDR_W-1:0] addr_wr
);
  // Address holds between writes so the bank sees a stable bus.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      we      <= 1'b0;
      addr_wr <= '0;
    end else begin
      we <= wr;
      if (wr) addr_wr <= addr;
    end
  end
endmodule

module fft_input_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int GUARD  = 2
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic signed [DATA_W-1:0] iDATA,
  input  logic                     iVALID,
  input  logic                     iFFT_RDY,
  input  logic                     iCLR,
  output logic signed [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0]        oADDR_WR_0,
  output logic [ADDR_W-1:0]        oADDR_WR_1,
  output logic [ADDR_W-1:0]        oADDR_WR_2,
  output logic [ADDR_W-1:0]        oADDR_WR_3,
  output logic                     oWE_0,
  output logic                     oWE_1,
  output logic                     oWE_2,
  output logic                     oWE_3,
  output logic                     oSTART,
  output logic                     oBUSY,
  output logic                     oOVF,
  output logic [15:0]              oDROP_CNT
);
  localparam int NUM_BANKS = 4;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT_FFT} state_t;

  state_t                              state;
  logic [1:0]                          bank;
  logic [ADDR_W-1:0]                   addr;
  logic [3:0]                          guard;
  logic                                store, drop;
  logic [NUM_BANKS-1:0]                wr, we;
  logic [NUM_BANKS-1:0][ADDR_W-1:0]    addr_wr;

  assign store = (state == FILL) && iVALID;
  assign drop  = (state != FILL) && iVALID;
  assign wr    = store ? 4'(4'b0001 << bank) : 4'b0000;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    fft_bank_port #(.ADDR_W(ADDR_W)) u_port (
      .iCLK    (iCLK),
      .iRESET  (iRESET),
      .wr      (wr[g]),
      .addr    (addr),
      .we      (we[g]),
      .addr_wr (addr_wr[g])
    );
  end

  assign {oWE_3, oWE_2, oWE_1, oWE_0} = we;
  assign oADDR_WR_0 = addr_wr[0];
  assign oADDR_WR_1 = addr_wr[1];
  assign oADDR_WR_2 = addr_wr[2];
  assign oADDR_WR_3 = addr_wr[3];

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state  <= FILL;
      bank   <= '0;
      addr   <= '0;
      guard  <= '0;
      oDATA  <= '0;
      oSTART <= 1'b0;
      oBUSY  <= 1'b0;
    end else begin
      oSTART <= 1'b0;
      case (state)
        FILL: if (iVALID) begin
          oDATA <= iDATA;
          addr  <= addr + 1'b1;
          if (&addr) begin
            bank <= bank + 1'b1;
            if (&bank) begin
              state <= LAUNCH;
              oBUSY <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state  <= WAIT_FFT;
          oSTART <= 1'b1;
          guard  <= 4'(GUARD);
        end
        WAIT_FFT: begin
          // Guard spans the WAIT cycles themselves: the last guard cycle may exit.
          if (guard != 4'd0) guard <= guard - 4'd1;
          if (guard <= 4'd1 && iFFT_RDY) begin
            state <= FILL;
            oBUSY <= 1'b0;
            guard <= '0;
          end
        end
        default: begin
          state <= FILL;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

  // A clear coinciding with a drop keeps that drop.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oOVF      <= 1'b0;
      oDROP_CNT <= '0;
    end else if (iCLR) begin
      oOVF      <= drop;
      oDROP_CNT <= {15'd0, drop};
    end else if (drop) begin
      oOVF <= 1'b1;
      if (oDROP_CNT != 16'hFFFF) oDROP_CNT <= oDROP_CNT + 16'd1;
    end
  end
endmodule
